// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART echo controller: FSM states,
// bus addresses and the baud divisor table indexed by br_cfg.
package spart_pkg;

   typedef enum logic [2:0] {
      CFG_LO,
      CFG_HI,
      IDLE,
      RD,
      WR,
      GAP
   } state_t;

   localparam logic [1:0] ADDR_RX  = 2'b00;
   localparam logic [1:0] ADDR_TX  = 2'b01;
   localparam logic [1:0] ADDR_DBL = 2'b10;
   localparam logic [1:0] ADDR_DBH = 2'b11;

   // 4800, 9600, 19200, 38400 baud
   localparam logic [15:0] DIV_TABLE [4] = '{16'h028A, 16'h0145, 16'h00A2, 16'h0050};

endpackage

// File: rtl/spart_fifo.sv
// Synchronous FIFO; dout shows the head combinationally, count updates one cycle after push/pop.
// Push when full and pop when empty are ignored; DEPTH must be a power of 2 so pointers wrap naturally.
module spart_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spart_echo_ctrl.sv
// SPART bus master: programs the baud divisor, then echoes RX bytes through a FIFO (RD->WR in 3 cycles).
// Full FIFO leaves rda unserviced; with SPART_OVERRUN_CNT_EN the byte is read, dropped and counted.
module spart_echo_ctrl
   import spart_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [1:0]                   br_cfg,
   input  logic                         rda,
   input  logic                         tbr,
   output logic                         iocs,
   output logic                         iorw,
   output logic [1:0]                   ioaddr,
   inout  wire  [7:0]                   databus,
   output logic                         cfg_done,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count
`ifdef SPART_OVERRUN_CNT_EN
   ,
   output logic [7:0]                   overrun_cnt
`endif
);

   state_t      state;
   logic [1:0]  br_cfg_q;
   logic        cfg_chg;
   logic        rd_go;
   logic        full;
   logic        empty;
   logic        push;
   logic        pop;
   logic [7:0]  fifo_dout;
   logic [15:0] div_new;
   logic [15:0] div_cur;
   logic        acc;
   logic        acc_rw;
   logic [1:0]  acc_addr;
   logic [7:0]  wr_dat;

   assign cfg_chg = (br_cfg != br_cfg_q);
   assign div_new = DIV_TABLE[br_cfg];
   assign div_cur = DIV_TABLE[br_cfg_q];

`ifdef SPART_OVERRUN_CNT_EN
   assign rd_go = rda;
`else
   assign rd_go = rda && !full;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= CFG_LO;
         br_cfg_q <= 2'b00;
         cfg_done <= 1'b0;
      end else begin
         unique case (state)
            CFG_LO: begin
               br_cfg_q <= br_cfg;
               state    <= CFG_HI;
            end
            CFG_HI: begin
               if (cfg_chg) begin
                  state <= CFG_LO;
               end else begin
                  cfg_done <= 1'b1;
                  state    <= GAP;
               end
            end
            IDLE: begin
               if (cfg_chg) begin
                  cfg_done <= 1'b0;
                  state    <= CFG_LO;
               end else if (cfg_done && rd_go) begin
                  state <= RD;
               end else if (cfg_done && tbr && !empty) begin
                  state <= WR;
               end
            end
            RD:      state <= GAP;
            WR:      state <= GAP;
            GAP:     state <= IDLE;
            default: state <= CFG_LO;
         endcase
      end
   end

   // Access strobes decode straight from state so iocs covers the whole state cycle.
   always_comb begin
      acc      = 1'b0;
      acc_rw   = 1'b1;
      acc_addr = ADDR_RX;
      wr_dat   = 8'h00;
      unique case (state)
         CFG_LO: begin
            acc      = 1'b1;
            acc_rw   = 1'b0;
            acc_addr = ADDR_DBL;
            wr_dat   = div_new[7:0];
         end
         CFG_HI: begin
            acc      = 1'b1;
            acc_rw   = 1'b0;
            acc_addr = ADDR_DBH;
            wr_dat   = div_cur[15:8];
         end
         RD: begin
            acc      = 1'b1;
            acc_rw   = 1'b1;
            acc_addr = ADDR_RX;
         end
         WR: begin
            acc      = 1'b1;
            acc_rw   = 1'b0;
            acc_addr = ADDR_TX;
            wr_dat   = fifo_dout;
         end
         default: begin
            acc = 1'b0;
         end
      endcase
   end

   // Reset masks the bus immediately so an access in flight is abandoned.
   assign iocs    = acc && !rst;
   assign iorw    = acc_rw || rst;
   assign ioaddr  = rst ? ADDR_RX : acc_addr;
   assign databus = (iocs && !iorw) ? wr_dat : 8'hzz;

   assign push = (state == RD) && !full && !rst;
   assign pop  = (state == WR) && !rst;

   spart_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (databus),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

`ifdef SPART_OVERRUN_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_cnt <= 8'h00;
      end else if ((state == RD) && full && (overrun_cnt != 8'hFF)) begin
         overrun_cnt <= overrun_cnt + 8'h01;
      end
   end
`endif

endmodule

// File: tb/tb_spart_echo_ctrl.sv
// Bench for spart_echo_ctrl: SPART model on the bus, scoreboard of expected bus accesses,
// table of baud settings plus cycle-exact sequences for echo, overrun, reprogramming and reset.
module tb_spart_echo_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] br_cfg = 2'b00;
   logic       rda = 1'b0;
   logic       tbr = 1'b0;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   wire  [7:0] databus;
   logic       cfg_done;
   logic [3:0] fifo_count;
`ifdef SPART_OVERRUN_CNT_EN
   logic [7:0] overrun_cnt;
`endif

   logic       probe = 1'b0;
   logic [7:0] rx_dat = 8'h00;

   always #5 clk = ~clk;

   // SPART side: returns RX data on reads; probe drives a marker to show the DUT has released the bus.
   assign databus = probe ? 8'hC3 : ((iocs && iorw) ? rx_dat : 8'hzz);

   spart_echo_ctrl #(.FIFO_DEPTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .br_cfg     (br_cfg),
      .rda        (rda),
      .tbr        (tbr),
      .iocs       (iocs),
      .iorw       (iorw),
      .ioaddr     (ioaddr),
      .databus    (databus),
      .cfg_done   (cfg_done),
      .fifo_count (fifo_count)
`ifdef SPART_OVERRUN_CNT_EN
      ,
      .overrun_cnt(overrun_cnt)
`endif
   );

   typedef struct packed {
      logic       rw;
      logic [1:0] addr;
      logic [7:0] dat;
   } acc_t;

   typedef struct {
      logic [1:0] br;
      logic [7:0] lo;
      logic [7:0] hi;
   } cfg_vec_t;

   acc_t       exp_q[$];
   logic [7:0] rx_q[$];
   logic       pend_pop = 1'b0;
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic acc_t mk(input logic rw, input logic [1:0] addr, input logic [7:0] dat);
      acc_t a;
      a.rw   = rw;
      a.addr = addr;
      a.dat  = dat;
      return a;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic drain(input string name, input int max);
      int i = 0;
      while (exp_q.size() > 0 && i < max) begin
         @(posedge clk);
         i++;
      end
      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d bus accesses still pending after %0d cycles", name, exp_q.size(), max);
         exp_q.delete();
      end
   endtask

   task automatic reset_and_check(input logic [1:0] br);
      rst    = 1'b1;
      probe  = 1'b1;
      br_cfg = br;
      tick(2);
      at_neg();
      chk("rst_iocs", 16'(iocs), 16'h0);
      chk("rst_iorw", 16'(iorw), 16'h1);
      chk("rst_ioaddr", 16'(ioaddr), 16'h0);
      chk("rst_databus_released", 16'(databus), 16'h00C3);
      chk("rst_cfg_done", 16'(cfg_done), 16'h0);
      chk("rst_fifo_count", 16'(fifo_count), 16'h0);
      @(posedge clk);
      #2;
      rst   = 1'b0;
      probe = 1'b0;
   endtask

   // Bus monitor and RX model: every access is checked against the scoreboard.
   initial begin
      acc_t       a;
      acc_t       e;
      logic [7:0] dropped;
      forever begin
         @(negedge clk);
         if (pend_pop) begin
            if (rx_q.size() > 0) begin
               dropped = rx_q.pop_front();
            end
            pend_pop = 1'b0;
         end
         if (!rst && iocs) begin
            a = {iorw, ioaddr, databus};
            if (iorw && ioaddr == 2'b00) begin
               pend_pop = 1'b1;
            end
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_access: got rw=%0b addr=%0d dat=%h expected none", a.rw, a.addr, a.dat);
            end else begin
               e = exp_q.pop_front();
               chk("bus_access", 16'(a), 16'(e));
            end
         end
         rda    = (rx_q.size() > 0);
         rx_dat = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached with %0d checks", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      cfg_vec_t tbl[4];
      tbl[0] = '{2'b00, 8'h8A, 8'h02};
      tbl[1] = '{2'b10, 8'hA2, 8'h00};
      tbl[2] = '{2'b11, 8'h50, 8'h00};
      tbl[3] = '{2'b01, 8'h45, 8'h01};

      // Divisor programming for every baud setting
      for (int r = 0; r < 4; r++) begin
         exp_q.push_back(mk(1'b0, 2'b10, tbl[r].lo));
         exp_q.push_back(mk(1'b0, 2'b11, tbl[r].hi));
         reset_and_check(tbl[r].br);
         at_neg();
         chk("cfg_lo_iocs", 16'(iocs), 16'h1);
         chk("cfg_lo_addr", 16'(ioaddr), 16'h2);
         at_neg();
         chk("cfg_hi_addr", 16'(ioaddr), 16'h3);
         chk("cfg_hi_done", 16'(cfg_done), 16'h0);
         at_neg();
         chk("cfg_done_rise", 16'(cfg_done), 16'h1);
         chk("gap_iocs", 16'(iocs), 16'h0);
         drain("cfg_table", 20);
      end

      // Single echo, cycle exact
      tbr = 1'b1;
      rx_q.push_back(8'h5A);
      exp_q.push_back(mk(1'b1, 2'b00, 8'h5A));
      exp_q.push_back(mk(1'b0, 2'b01, 8'h5A));
      at_neg();
      chk("echo_idle_count", 16'(fifo_count), 16'h0);
      at_neg();
      chk("echo_rd_iocs", 16'(iocs), 16'h1);
      chk("echo_rd_iorw", 16'(iorw), 16'h1);
      chk("echo_rd_addr", 16'(ioaddr), 16'h0);
      at_neg();
      chk("echo_gap_count", 16'(fifo_count), 16'h1);
      chk("echo_gap_iocs", 16'(iocs), 16'h0);
      at_neg();
      chk("echo_idle2_iocs", 16'(iocs), 16'h0);
      at_neg();
      chk("echo_wr_iocs", 16'(iocs), 16'h1);
      chk("echo_wr_iorw", 16'(iorw), 16'h0);
      chk("echo_wr_addr", 16'(ioaddr), 16'h1);
      chk("echo_wr_data", 16'(databus), 16'h005A);
      at_neg();
      chk("echo_after_count", 16'(fifo_count), 16'h0);
      drain("echo", 20);

      // Fill past capacity with the transmitter stalled
      tbr = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         rx_q.push_back(8'(8'h10 + i));
      end
      for (int i = 1; i <= 8; i++) begin
         exp_q.push_back(mk(1'b1, 2'b00, 8'(8'h10 + i)));
      end
`ifdef SPART_OVERRUN_CNT_EN
      exp_q.push_back(mk(1'b1, 2'b00, 8'h19));
`endif
      drain("fill", 200);
      tick(6);
      at_neg();
      chk("full_count", 16'(fifo_count), 16'h8);
`ifdef SPART_OVERRUN_CNT_EN
      chk("overrun_cnt", 16'(overrun_cnt), 16'h1);
      chk("overrun_rx_taken", 16'(rx_q.size()), 16'h0);
`else
      chk("full_rx_left", 16'(rx_q.size()), 16'h1);
      chk("full_rda_held", 16'(rda), 16'h1);
`endif
      exp_q.push_back(mk(1'b0, 2'b01, 8'h11));
`ifndef SPART_OVERRUN_CNT_EN
      exp_q.push_back(mk(1'b1, 2'b00, 8'h19));
`endif
      for (int i = 2; i <= 8; i++) begin
         exp_q.push_back(mk(1'b0, 2'b01, 8'(8'h10 + i)));
      end
`ifndef SPART_OVERRUN_CNT_EN
      exp_q.push_back(mk(1'b0, 2'b01, 8'h19));
`endif
      @(posedge clk);
      #2;
      tbr = 1'b1;
      drain("release", 200);
      at_neg();
      chk("drained_count", 16'(fifo_count), 16'h0);

      // br_cfg change while the high byte is being written
      exp_q.push_back(mk(1'b0, 2'b10, 8'h8A));
      exp_q.push_back(mk(1'b0, 2'b11, 8'h02));
      exp_q.push_back(mk(1'b0, 2'b10, 8'h50));
      exp_q.push_back(mk(1'b0, 2'b11, 8'h00));
      @(posedge clk);
      #2;
      reset_and_check(2'b00);
      @(posedge clk);
      #2;
      br_cfg = 2'b11;
      at_neg();
      chk("chg_hi_addr", 16'(ioaddr), 16'h3);
      at_neg();
      chk("chg_restart_addr", 16'(ioaddr), 16'h2);
      chk("chg_restart_done", 16'(cfg_done), 16'h0);
      at_neg();
      chk("chg_hi2_addr", 16'(ioaddr), 16'h3);
      at_neg();
      chk("chg_done", 16'(cfg_done), 16'h1);
      drain("cfg_change", 20);

      // rda and br_cfg change in the same IDLE cycle: reprogram first
      br_cfg = 2'b01;
      rx_q.push_back(8'h33);
      exp_q.push_back(mk(1'b0, 2'b10, 8'h45));
      exp_q.push_back(mk(1'b0, 2'b11, 8'h01));
      exp_q.push_back(mk(1'b1, 2'b00, 8'h33));
      exp_q.push_back(mk(1'b0, 2'b01, 8'h33));
      at_neg();
      chk("race_idle_done", 16'(cfg_done), 16'h1);
      at_neg();
      chk("race_cfg_first", 16'(ioaddr), 16'h2);
      chk("race_done_clr", 16'(cfg_done), 16'h0);
      drain("race", 50);
      at_neg();
      chk("race_count", 16'(fifo_count), 16'h0);

      // Reset in the middle of a TX write
      @(posedge clk);
      #2;
      tick(1);
      rx_q.push_back(8'h77);
      exp_q.push_back(mk(1'b1, 2'b00, 8'h77));
      tick(3);
      @(posedge clk);
      #1;
      chk("pre_rst_wr_iocs", 16'(iocs), 16'h1);
      chk("pre_rst_wr_iorw", 16'(iorw), 16'h0);
      chk("pre_rst_count", 16'(fifo_count), 16'h1);
      #1;
      rst   = 1'b1;
      probe = 1'b1;
      at_neg();
      chk("wr_rst_iocs", 16'(iocs), 16'h0);
      chk("wr_rst_databus", 16'(databus), 16'h00C3);
      @(posedge clk);
      #2;
      at_neg();
      chk("post_rst_count", 16'(fifo_count), 16'h0);
      chk("post_rst_iocs", 16'(iocs), 16'h0);
      chk("post_rst_done", 16'(cfg_done), 16'h0);
      exp_q.push_back(mk(1'b0, 2'b10, 8'h45));
      exp_q.push_back(mk(1'b0, 2'b11, 8'h01));
      @(posedge clk);
      #2;
      rst   = 1'b0;
      probe = 1'b0;
      at_neg();
      chk("reprog_iocs", 16'(iocs), 16'h1);
      chk("reprog_addr", 16'(ioaddr), 16'h2);
      drain("reprog", 20);
      tick(10);
      at_neg();
      chk("final_count", 16'(fifo_count), 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spart_echo_ctrl.md
# spart_echo_ctrl

Bus master for the SPART register interface that replaces the free-running driver with a sequenced controller. After reset or a `br_cfg` change, it programs the baud divisor. It then drains received bytes into an internal FIFO and retransmits them through the transmit buffer (echo), arbitrating reads, writes and reprogramming onto the single `iocs/iorw/ioaddr/databus` bus. It sits between the board switches and the `spart` instance in the top level.

## Interface
- `FIFO_DEPTH`, default 8: echo FIFO entries; power of 2, minimum 2.
- `clk` input, 1 bit: system clock. One clock domain.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `br_cfg` input, 2 bits: baud select. 00 selects 4800, 01 selects 9600, 10 selects 19200, 11 selects 38400.
- `rda` input, 1 bit: SPART receive data available.
- `tbr` input, 1 bit: SPART transmit buffer ready.
- `iocs` output, 1 bit: chip select, high for exactly one cycle per bus access.
- `iorw` output, 1 bit: 1 = read (SPART→ctrl), 0 = write (ctrl→SPART).
- `ioaddr` output, 2 bits: 00 = RX buffer, 01 = TX buffer, 10 = DB low, 11 = DB high.
- `databus` inout, 8 bits: driven only when `iocs && !iorw`; otherwise high-Z.
- `cfg_done` output, 1 bit: divisor programmed for current `br_cfg_q`.
- `fifo_count` output, $clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.
- `overrun_cnt` output, 8 bits: dropped-byte count. Present only with `SPART_OVERRUN_CNT_EN`.

## Operation
- Divisors are 650 (0x028A), 325 (0x0145), 162 (0x00A2) and 80 (0x0050), indexed by `br_cfg`.
- States: CFG_LO, CFG_HI, IDLE, RD, WR, GAP.
- CFG_LO:
  - Latch `br_cfg` into `br_cfg_q`.
  - Write the divisor low byte to 10.
  - Go to CFG_HI.
- CFG_HI:
  - Write the divisor high byte (from `br_cfg_q`) to 11.
  - If `br_cfg != br_cfg_q`, go to CFG_LO. Otherwise set `cfg_done` and go to GAP.
- IDLE priority, highest first:
  1. `br_cfg != br_cfg_q`: clear `cfg_done`, go to CFG_LO.
  2. `rda && !full`: go to RD.
  3. `tbr && !empty`: go to WR.
  4. Otherwise stay in IDLE.
- RD:
  - Drive `iocs=1`, `iorw=1`, `ioaddr=00`.
  - Sample `databus` at the end of the cycle and push it to the FIFO.
  - Go to GAP.
- WR:
  - Pop the FIFO head and drive it on `databus` with `iocs=1`, `iorw=0`, `ioaddr=01`.
  - Go to GAP.
- GAP: one idle cycle so the SPART can update `rda/tbr`. Go to IDLE.
- Push and pop never occur in the same cycle.
- FIFO pointers wrap modulo `FIFO_DEPTH`. `full` is `count == FIFO_DEPTH`; `empty` is `count == 0`.
- A `br_cfg` change during RD/WR/GAP is honoured at the next IDLE. The FIFO contents are preserved across reprogramming.
- `cfg_done=0` blocks RD/WR. The controller never echoes before the divisor has been written.

## Timing
- Reset values (asserted the cycle after `rst` is sampled high):
  - State CFG_LO.
  - `iocs=0`, `iorw=1`, `ioaddr=00`, `databus` high-Z.
  - `cfg_done=0`, `fifo_count=0`, `overrun_cnt=0`.
- Reset mid-access aborts the access; the FIFO is emptied.
- First bus cycle after reset deassertion: DB low write. The next cycle is the DB high write. `cfg_done` rises the cycle after DB high.
- Access outputs are combinational from state, so `iocs` is valid for the full state cycle.
- Minimum spacing between accesses is 2 cycles (access + GAP). IDLE adds 1 cycle of decision latency.
- Echo latency, from `rda` seen in IDLE to the TX write: RD (N), GAP (N+1), IDLE (N+2), WR (N+3), given `tbr=1`.
- `fifo_count` updates the cycle after RD/WR.

## Configuration
- Macro `SPART_OVERRUN_CNT_EN` defined:
  - When `rda && full` in IDLE (and no `br_cfg` change), perform RD anyway and discard the byte.
  - `overrun_cnt` increments, saturating at 255.
- Macro `SPART_OVERRUN_CNT_EN` undefined:
  - `rda` is ignored while full, so the byte stays in the SPART.
  - The `overrun_cnt` port is absent.

## Structure
- `spart_pkg` holds:
  - The `state_t` enum.
  - Address constants `ADDR_RX`, `ADDR_TX`, `ADDR_DBL`, `ADDR_DBH`.
  - The 16-bit divisor table indexed by `br_cfg`.
- Sub-module `spart_fifo`: synchronous FIFO with `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`, and a synchronous active-high `rst`.
- The top holds the FSM, `br_cfg_q`, the tristate and the overrun counter.

## Test plan
- Reset with `br_cfg=01`, then release → writes 0x45@10, then 0x01@11 on consecutive cycles. `cfg_done=1` one cycle later.
- With `cfg_done=1`, pulse `rda` with bus data 0x5A and hold `tbr=1` → RD at N, WR of 0x5A@01 at N+3, `fifo_count` 0→1→0.
- Hold `tbr=0` and feed 9 bytes with depth 8:
  - With the macro: 9 reads and `overrun_cnt=1`; releasing `tbr` echoes the first 8 in order.
  - Without the macro: the 9th `rda` is left unserviced.
- Change `br_cfg` 00→11 during CFG_HI → CFG_LO restarts and the final writes are 0x50@10, 0x00@11.
- Assert `rda` and change `br_cfg` in the same IDLE cycle → reprogramming happens first, then RD.
- Assert `rst` during WR → `iocs=0`, `databus` high-Z, and `fifo_count=0` the next cycle, followed by a fresh programming sequence.
